// File: rtl/conv_rd_bridge.sv
// Read bridge: one tagged AR burst per addr_en, matching R beats buffered in a show-ahead FIFO.
// AR valid 1 cycle after addr_en, beat at data_out 1 cycle after accept; rready drops on full FIFO or foreign ID.

module conv_rd_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push_vld,
  input  logic [W-1:0]             i_push_dat,
  input  logic                     i_pop,
  output logic [W-1:0]             o_head_dat,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_pop;

  assign w_pop      = i_pop && (r_count != '0);
  assign o_head_dat = r_mem[r_rd_ptr];
  assign o_count    = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push_vld) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)      r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_push_vld, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; the count alone defines what is valid.
  always_ff @(posedge clk) begin
    if (i_push_vld) r_mem[r_wr_ptr] <= i_push_dat;
  end
endmodule

module conv_rd_bridge #(
  parameter int         width = 32,
  parameter int         DEPTH = 8,
  parameter logic [3:0] RD_ID = 4'h1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [27:0]      addr,
  input  logic [5:0]       addr_bias,
  input  logic [3:0]       len,
  input  logic             addr_en,
  output logic             addr_rq,
  output logic [27:0]      araddr,
  output logic             aruser_ap,
  output logic [3:0]       aruser_id,
  output logic [3:0]       arlen,
  output logic             arvalid,
  input  logic             arready,
  input  logic [width-1:0] rdata,
  input  logic             rvalid,
  input  logic [3:0]       ruser_id,
  input  logic             ruser_last,
  output logic             rready,
  output logic [width-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             burst_done,
  output logic             err
);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [3:0]    r_beat_cnt;
  logic [3:0]    r_burst_len;
  logic [3:0]    w_len_eff;
  logic [CW-1:0] w_fifo_count;
  logic          w_accept;
  logic          w_cnt_hit;
  logic          w_complete;

  assign w_len_eff  = (len == 4'd0) ? 4'd1 : len;
  assign rready     = (r_state == DATA) && (w_fifo_count < CW'(DEPTH)) && (ruser_id == RD_ID);
  assign w_accept   = rvalid && rready;
  assign w_cnt_hit  = (({1'b0, r_beat_cnt} + 5'd1) == {1'b0, r_burst_len});
  assign w_complete = w_accept && (w_cnt_hit || ruser_last);
  assign data_valid = (w_fifo_count != '0);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (addr_en)    w_state_nxt = REQ;
      REQ:     if (arready)    w_state_nxt = DATA;
      DATA:    if (w_complete) w_state_nxt = IDLE;
      default:                 w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_beat_cnt  <= '0;
      r_burst_len <= '0;
      addr_rq     <= 1'b0;
      araddr      <= '0;
      aruser_ap   <= 1'b0;
      aruser_id   <= '0;
      arlen       <= '0;
      arvalid     <= 1'b0;
      burst_done  <= 1'b0;
      err         <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      addr_rq    <= (w_state_nxt == IDLE);
      burst_done <= w_complete;
      // Completion by count and by last must agree, otherwise flag it until reset.
      if (w_complete && (w_cnt_hit != ruser_last)) err <= 1'b1;
      if (r_state == IDLE && addr_en) begin
        araddr      <= addr + {22'b0, addr_bias};
        arlen       <= w_len_eff;
        r_burst_len <= w_len_eff;
        r_beat_cnt  <= '0;
        arvalid     <= 1'b1;
        aruser_ap   <= 1'b1;
        aruser_id   <= RD_ID;
      end else if (r_state == REQ && arready) begin
        araddr    <= '0;
        arlen     <= '0;
        arvalid   <= 1'b0;
        aruser_ap <= 1'b0;
        aruser_id <= '0;
      end
      if (w_accept) r_beat_cnt <= r_beat_cnt + 4'd1;
    end
  end

  conv_rd_fifo #(
    .W     (width),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push_vld (w_accept),
    .i_push_dat (rdata),
    .i_pop      (data_ready),
    .o_head_dat (data_out),
    .o_count    (w_fifo_count)
  );
endmodule
